// File: rtl/exp_display_sequencer.sv
// Exponentiation sequencer: computes a**n by repeated multiply, then
// hands the result to a display writer and waits (bounded) for completion.
module exp_display_sequencer #(
  parameter logic [31:0] DISP_TIMEOUT = 32'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  a_in,
  input  logic [7:0]  n_in,
  input  logic        disp_done,
  output logic        disp_start,
  output logic [7:0]  a_out,
  output logic [7:0]  n_out,
  output logic [15:0] res_out,
  output logic        busy,
  output logic        overflow,
  output logic        disp_err,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    MUL       = 3'd2,
    DISP_REQ  = 3'd3,
    DISP_WAIT = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] tcnt, tcnt_n;
  logic [7:0]  a_n, n_n;
  logic [15:0] res_n;
  logic        ovf_n, err_n;
  logic [23:0] prod;

  assign prod = {8'h00, res_out} * {16'h0000, a_out};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'h00;
      tcnt     <= 32'h0;
      a_out    <= 8'h00;
      n_out    <= 8'h00;
      res_out  <= 16'h0000;
      overflow <= 1'b0;
      disp_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tcnt     <= tcnt_n;
      a_out    <= a_n;
      n_out    <= n_n;
      res_out  <= res_n;
      overflow <= ovf_n;
      disp_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    a_n     = a_out;
    n_n     = n_out;
    res_n   = res_out;
    ovf_n   = overflow;
    err_n   = disp_err;
    case (state)
      IDLE: begin
        if (go) begin
          a_n     = a_in;
          n_n     = n_in;
          cnt_n   = n_in;
          res_n   = 16'h0001;
          ovf_n   = 1'b0;
          err_n   = 1'b0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        state_n = (cnt != 8'h00) ? MUL : DISP_REQ;
      end
      MUL: begin
        res_n = prod[15:0];
        if (prod[23:16] != 8'h00) ovf_n = 1'b1;
        cnt_n = cnt - 8'd1;
        // cnt==0 is unreachable here; treat it as the last iteration
        if (cnt <= 8'd1) begin
          cnt_n   = 8'h00;
          state_n = DISP_REQ;
        end
      end
      DISP_REQ: begin
        tcnt_n  = 32'h0;
        state_n = DISP_WAIT;
      end
      DISP_WAIT: begin
        if (disp_done) begin
          state_n = FINISH;
        end else begin
          tcnt_n = tcnt + 32'd1;
          if (tcnt_n >= DISP_TIMEOUT) begin
            err_n   = 1'b1;
            state_n = FINISH;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign disp_start = (state == DISP_REQ);
  assign done       = (state == FINISH);

endmodule

// File: tb/tb_exp_display_sequencer.sv
// Directed bench for exp_display_sequencer: hand-computed powers,
// pulse latencies, display timeout and mid-operation reset.
module tb_exp_display_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  n_in = 8'h00;
  logic        disp_done = 1'b0;
  logic        disp_start;
  logic [7:0]  a_out;
  logic [7:0]  n_out;
  logic [15:0] res_out;
  logic        busy;
  logic        overflow;
  logic        disp_err;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int starts = 0;
  int dones = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit noisy = 1'b0;

  exp_display_sequencer #(.DISP_TIMEOUT(32'd20)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .a_in       (a_in),
    .n_in       (n_in),
    .disp_done  (disp_done),
    .disp_start (disp_start),
    .a_out      (a_out),
    .n_out      (n_out),
    .res_out    (res_out),
    .busy       (busy),
    .overflow   (overflow),
    .disp_err   (disp_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (disp_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
    end
    if (done) begin
      dones    <= dones + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation; k>0 raises disp_done during the k-th cycle
  // after disp_start, k==0 never answers.
  task automatic run(input logic [7:0] a, input logic [7:0] n,
                     input int k, output int s_lat, output int d_lat);
    int g, s0, d0, t;
    s0 = starts;
    d0 = dones;
    @(posedge clk); #1;
    go = 1'b1; a_in = a; n_in = n;
    g = cyc + 1;
    @(posedge clk); #1;
    go = 1'b0;
    t = 0;
    while (starts == s0 && t < 1000) begin
      @(negedge clk); #1;
      if (noisy) begin go = 1'b1; a_in = 8'hAA; n_in = 8'h55; end
      t++;
    end
    if (t >= 1000) check("start_seen", 0, 1);
    s_lat = start_cyc - g;
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1 disp_done = 1'b1;
    end
    t = 0;
    while (dones == d0 && t < 1000) begin
      @(negedge clk); #1;
      if (noisy) begin go = 1'b1; a_in = 8'hAA; n_in = 8'h55; end
      t++;
    end
    go = 1'b0;
    if (t >= 1000) check("done_seen", 0, 1);
    d_lat = done_cyc - start_cyc;
    disp_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("one_start", starts - s0, 1);
    check("one_done", dones - d0, 1);
  endtask

  int sl, dl, d0, s0;

  initial begin
    #12;
    check("rst_res", res_out, 16'h0000);
    check("rst_a", a_out, 8'h00);
    check("rst_n", n_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", disp_err, 0);
    check("rst_done", done, 0);
    check("rst_start", disp_start, 0);
    @(negedge clk);
    rst = 1'b0;

    // 3**4 with a 5-cycle display answer
    run(8'h03, 8'h04, 5, sl, dl);
    check("p34_slat", sl, 5);
    check("p34_dlat", dl, 6);
    check("p34_res", res_out, 16'h0051);
    check("p34_ovf", overflow, 0);
    check("p34_err", disp_err, 0);
    check("p34_busy", busy, 0);
    check("p34_a", a_out, 8'h03);
    check("p34_n", n_out, 8'h04);
    repeat (4) @(negedge clk);
    check("hold_res", res_out, 16'h0051);

    // 2**16 truncates to zero and keeps multiplying
    run(8'h02, 8'h10, 2, sl, dl);
    check("p216_slat", sl, 17);
    check("p216_res", res_out, 16'h0000);
    check("p216_ovf", overflow, 1);

    // n=0: LOAD straight to DISP_REQ; overflow cleared by new go
    run(8'hFF, 8'h00, 3, sl, dl);
    check("n0_slat", sl, 1);
    check("n0_res", res_out, 16'h0001);
    check("n0_ovf", overflow, 0);

    // 16**3 = 0x1000, then 15**2 = 0xE1
    run(8'h10, 8'h03, 1, sl, dl);
    check("p163_res", res_out, 16'h1000);
    check("p163_dlat", dl, 2);
    run(8'h0F, 8'h02, 1, sl, dl);
    check("p152_res", res_out, 16'h00E1);

    // go hammered while busy
    noisy = 1'b1;
    run(8'h03, 8'h04, 5, sl, dl);
    noisy = 1'b0;
    check("noise_res", res_out, 16'h0051);
    check("noise_a", a_out, 8'h03);
    check("noise_n", n_out, 8'h04);
    check("noise_slat", sl, 5);

    // display never answers
    run(8'h03, 8'h01, 0, sl, dl);
    check("to_dlat", dl, 21);
    check("to_err", disp_err, 1);
    check("to_res", res_out, 16'h0003);

    // answer arrives on the expiry cycle
    run(8'h03, 8'h01, 20, sl, dl);
    check("tie_dlat", dl, 21);
    check("tie_err", disp_err, 0);

    // reset during the 2nd MUL cycle of 3**5
    d0 = dones;
    s0 = starts;
    @(posedge clk); #1;
    go = 1'b1; a_in = 8'h03; n_in = 8'h05;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mr_res", res_out, 16'h0000);
    check("mr_a", a_out, 8'h00);
    check("mr_n", n_out, 8'h00);
    check("mr_busy", busy, 0);
    check("mr_flags", {overflow, disp_err, done, disp_start}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("mr_nodone", dones - d0, 0);
    check("mr_nostart", starts - s0, 0);
    run(8'h03, 8'h05, 2, sl, dl);
    check("p35_res", res_out, 16'h00F3);
    check("p35_slat", sl, 6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
